// File: rtl/pc_link_pkg.sv
// pc_link_pkg: shared constants, TX state encoding and CRC-8 step for the PC link
package pc_link_pkg;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;
  localparam int ACK_TIMEOUT = 8;
  typedef enum logic [1:0] {IDLE, ACK, DONE} tx_state_t;
  function automatic logic [7:0] crc8_next(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ CRC8_POLY) : {r[6:0], 1'b0};
    return r;
  endfunction
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: 2**ADDR_W deep byte FIFO with registered count/full/empty
module byte_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            push,
  input  logic [7:0]      wdata,
  input  logic            pop,
  output logic [7:0]      rdata,
  output logic [ADDR_W:0] count,
  output logic            full,
  output logic            empty
);
  localparam int DEPTH = 2**ADDR_W;
  logic [7:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr, rptr;
  logic do_push, do_pop;
  logic [ADDR_W:0] count_n;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign count_n = count + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
  assign rdata = mem[rptr];
  // pointers wrap naturally; flags derive from next occupancy so they stay registered
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      wptr <= wptr + ADDR_W'(do_push);
      rptr <= rptr + ADDR_W'(do_pop);
      count <= count_n;
      full <= count_n == (ADDR_W+1)'(DEPTH);
      empty <= count_n == '0;
    end
  // storage needs no reset; only entries below count are ever read out
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= wdata;
endmodule

// File: rtl/crc.sv
// crc: running CRC-8 register, MSB-first, with synchronous clear
module crc
  import pc_link_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] crc_out
);
  // clear wins so a frame boundary always restarts from the init value
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) crc_out <= CRC8_INIT;
    else if (clr) crc_out <= CRC8_INIT;
    else if (en) crc_out <= crc8_next(crc_out, din);
endmodule

// File: rtl/pc_frame_buffer.sv
// pc_frame_buffer: buffers PC bytes, closes frames on RX silence with a CRC byte, drains to interfpga_send
module pc_frame_buffer
  import pc_link_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int IDLE_TICKS = 50000,
  parameter int APPEND_CRC = 1
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [7:0]      i_8_data,
  input  logic            i_valid,
  output logic [7:0]      o_8_data,
  output logic            o_send,
  input  logic            i_busy,
  output logic [7:0]      o_8_crc8,
  output logic [ADDR_W:0] o_count,
  output logic            o_full,
  output logic            o_empty,
  output logic            o_overflow,
  output logic            o_frame_done
);
  localparam int IW = $clog2(IDLE_TICKS + 1);
  localparam int TW = $clog2(ACK_TIMEOUT);
  logic [IW-1:0] idle_cnt;
  logic frame_open, frame_end, crc_push, push_req, push, byte_ok, pop;
  logic [7:0] wdata, rdata;
  logic [TW-1:0] tmo;
  tx_state_t state, state_n;
  assign frame_end = frame_open & ~i_valid & (idle_cnt == IW'(IDLE_TICKS - 1));
  assign crc_push = frame_end & (APPEND_CRC != 0);
  assign push_req = i_valid | crc_push;
  assign push = push_req & ~o_full;
  assign byte_ok = i_valid & ~o_full;
  assign wdata = i_valid ? i_8_data : o_8_crc8;
  byte_fifo #(.ADDR_W(ADDR_W)) u_fifo (
    .clk(clk), .nrst(nrst), .push(push), .wdata(wdata), .pop(pop),
    .rdata(rdata), .count(o_count), .full(o_full), .empty(o_empty)
  );
  crc u_crc (
    .clk(clk), .nrst(nrst), .clr(frame_end), .en(byte_ok), .din(i_8_data), .crc_out(o_8_crc8)
  );
  // frame tracking: any byte (even dropped) restarts the silence timer
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      frame_open <= 1'b0;
      idle_cnt <= '0;
      o_overflow <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      frame_open <= byte_ok ? 1'b1 : frame_end ? 1'b0 : frame_open;
      idle_cnt <= (i_valid | frame_end | ~frame_open) ? '0 : idle_cnt + IW'(1);
      o_overflow <= o_overflow | (push_req & o_full);
      o_frame_done <= frame_end;
    end
  // TX state register, send strobe and held output byte
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state <= IDLE;
      o_send <= 1'b0;
      o_8_data <= '0;
      tmo <= '0;
    end else begin
      state <= state_n;
      o_send <= pop;
      o_8_data <= pop ? rdata : o_8_data;
      tmo <= (state == ACK) ? tmo + TW'(1) : '0;
    end
  // TX next state: a missing busy acknowledge times out and counts the byte as sent
  always_comb begin
    pop = (state == IDLE) & ~o_empty & ~i_busy;
    state_n = state;
    case (state)
      IDLE: state_n = pop ? ACK : IDLE;
      ACK: state_n = i_busy ? DONE : (tmo == TW'(ACK_TIMEOUT - 1)) ? IDLE : ACK;
      DONE: state_n = i_busy ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: doc/pc_frame_buffer.md
Name: pc_frame_buffer

Overview:
- Sits between the PC-side `uart_receiver` (its data-ready passed through `single_pulser`) and `interfpga_send` on the transmitting FPGA.
- Buffers incoming PC bytes in a FIFO and drains them to `interfpga_send` one at a time using its send/busy handshake.
- Detects end of frame by RX silence, then appends that frame's CRC-8 as a trailing byte.
- Lets the PC send bursts without losing bytes while the inter-FPGA link is busy, and gives the receiving FPGA a checkable frame.

Parameters:
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W = 16 entries.
- IDLE_TICKS, 50000, clk cycles of no `i_valid` that close an open frame.
- APPEND_CRC, 1, 1 = push CRC byte at frame end; 0 = frame end only pulses `o_frame_done`.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- nrst  in  1  asynchronous active-low reset.
- i_8_data  in  8  byte from uart_receiver.
- i_valid  in  1  one-cycle pulse: `i_8_data` valid this cycle.
- o_8_data  out  8  byte presented to interfpga_send.
- o_send  out  1  one-cycle send request to interfpga_send.
- i_busy  in  1  interfpga_send busy.
- o_8_crc8  out  8  running CRC of the current open frame.
- o_count  out  ADDR_W+1  FIFO occupancy.
- o_full  out  1  occupancy == 2**ADDR_W.
- o_empty  out  1  occupancy == 0.
- o_overflow  out  1  sticky: a byte was dropped.
- o_frame_done  out  1  one-cycle pulse when a frame closes.

Behaviour:
- Reset (nrst low, asynchronous, any time incl. mid-transfer):
  - FIFO pointers, occupancy and CRC → 0; idle counter → 0; frame_open → 0; FSM → IDLE.
  - Outputs: o_8_data=0, o_send=0, o_8_crc8=0, o_count=0, o_full=0, o_empty=1, o_overflow=0, o_frame_done=0.
  - A transfer in flight is abandoned; no byte is re-sent after reset.
- CRC-8:
  - poly 0x07, init 0x00, MSB-first, no reflection, no final XOR.
  - Matches the shared `crc` module: 0x01→0x07, "123456789"→0xF4.
  - Updated on every accepted `i_valid` byte; dropped bytes excluded.
- Push (`i_valid` high):
  - If not full: write the byte, occupancy+1, CRC update, frame_open=1, idle counter=0.
  - If full: byte dropped, o_overflow=1 (cleared only by reset), CRC unchanged, idle counter still cleared.
- Frame end:
  - While frame_open, the idle counter increments each cycle without `i_valid`.
  - When it reaches IDLE_TICKS-1 and `i_valid` is low that cycle: o_frame_done pulses, frame_open=0, CRC reg → 0.
  - If APPEND_CRC, the pre-clear CRC value is pushed as a FIFO entry in that same cycle.
  - If the FIFO is full at that moment: CRC byte dropped, o_overflow=1.
  - `i_valid` in the threshold cycle cancels the frame end (the byte belongs to the current frame).
- Simultaneous push and pop: both happen, occupancy unchanged. A push into an empty FIFO cannot be popped in the same cycle.
- TX FSM states:
  - IDLE: if !empty && !i_busy → pop head into o_8_data, o_send=1 for one cycle → ACK.
  - ACK: wait for i_busy=1 → DONE. If busy is not seen within 8 cycles → IDLE (treats the send as a lost request; byte counted as sent).
  - DONE: wait for i_busy=0 → IDLE.
  - o_8_data holds the last sent byte until the next pop.
- Latency: byte sampled by `i_valid` at edge k into empty FIFO with FSM idle and busy low → o_send high in the cycle after edge k+1 (2 edges).
- Pointers wrap modulo 2**ADDR_W; occupancy uses ADDR_W+1 bits so full/empty are unambiguous.
- o_count, o_full, o_empty are registered and reflect state after the last edge.

Decomposition:
- Shared package `pc_link_pkg`:
  - CRC8_POLY = 8'h07 and CRC8_INIT = 8'h00.
  - FSM state encoding: IDLE, ACK, DONE.
  - ACK_TIMEOUT = 8.
- One sub-module: `byte_fifo` (parameter ADDR_W; ports clk, nrst, push, wdata, pop, rdata, count, full, empty).
- CRC update: reuse existing `crc` module instance, enabled by the accepted-push strobe; cleared via frame-end, not reset only.

Test Plan:
- Reset/idle: nrst low then high, no input → o_empty=1, o_count=0, o_send never asserts, o_8_crc8=0.
- Single byte: push 0x01, busy model responds (rise 1 cycle after send, 10 cycles high) → o_send 2 edges later with o_8_data=0x01; o_8_crc8=0x07. After IDLE_TICKS silence → o_frame_done, second send with o_8_data=0x07, CRC reg back to 0.
- CRC vector: push ASCII "123456789" back-to-back → 10 sends in order, last byte 0xF4.
- Overflow: busy held high, push 20 bytes 0x00..0x13 → o_full=1, o_count=16, o_overflow=1. Release busy → exactly 0x00..0x0F sent. CRC byte equals CRC of 0x00..0x0F only, pushed once space exists? No: it is dropped, since the FIFO is full at frame end → verify o_overflow stays 1 and no 17th send.
- Frame-end race: `i_valid` in exactly the IDLE_TICKS-1 cycle → no o_frame_done; frame closes IDLE_TICKS after that byte, single CRC covering all bytes.
- Reset mid-transfer: drop nrst while in DONE with 5 bytes queued → all outputs return to reset values immediately; after release no stale byte is sent.
